// File: rtl/button_gesture_pkg.sv
// Shared definitions for the button gesture classifier: state encoding and
// the millisecond-to-cycle conversion used to size the hold/gap timer.
// Optional feature macro: BUTTON_GESTURE_DOUBLE_EN (adds WAIT2/PRESS2 states).
package button_gesture_pkg;

`ifdef BUTTON_GESTURE_DOUBLE_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd4
    } state_t;
`endif

    // Whole-kHz clock times a duration in ms gives the duration in cycles.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_gesture_ms_timer.sv
// ms_timer: a clearable, enabled up-counter whose done output flags that the
// next enabled cycle lands the count exactly on the supplied limit.
module ms_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] count;

    // Count enabled cycles; clear has priority so a new phase always starts at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

    assign done = (count == limit - ONE);

endmodule

// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button into single, double and long
// press events, each a registered one-cycle pulse.
// Optional feature macro: BUTTON_GESTURE_DOUBLE_EN. When undefined, a release
// from the first press reports a single press immediately and evt_double is 0.
module button_gesture
    import button_gesture_pkg::*;
#(
    parameter int CLK_HZ  = 27_000_000,
    parameter int LONG_MS = 600,
    parameter int DBL_MS  = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed,
    output logic evt_single,
    output logic evt_double,
    output logic evt_long,
    output logic busy
);

    localparam int LONG_LIM = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int DBL_LIM  = ms_to_cycles(CLK_HZ, DBL_MS);
    localparam int MAX_LIM  = (LONG_LIM > DBL_LIM) ? LONG_LIM : DBL_LIM;
    localparam int CW       = $clog2(MAX_LIM + 1);

    localparam logic [CW-1:0] LONG_LIM_V = CW'(LONG_LIM);
`ifdef BUTTON_GESTURE_DOUBLE_EN
    localparam logic [CW-1:0] DBL_LIM_V  = CW'(DBL_LIM);
`endif

    state_t          state;
    state_t          state_next;
    logic            armed;
    logic            set_single;
    logic            set_long;
    logic            tmr_clear;
    logic            tmr_en;
    logic            tmr_done;
    logic [CW-1:0]   tmr_limit;
`ifdef BUTTON_GESTURE_DOUBLE_EN
    logic            set_double;
`endif

    ms_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .limit  (tmr_limit),
        .done   (tmr_done)
    );

    // Next-state and event decisions; release beats the long-press limit and a
    // second press beats the double-press gap timeout on the same edge.
    always_comb begin
        state_next = state;
        set_single = 1'b0;
        set_long   = 1'b0;
        tmr_en     = 1'b0;
        tmr_limit  = LONG_LIM_V;
`ifdef BUTTON_GESTURE_DOUBLE_EN
        set_double = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pressed && armed) begin
                    state_next = PRESS1;
                end
            end
            PRESS1: begin
                tmr_en = 1'b1;
                if (!pressed) begin
`ifdef BUTTON_GESTURE_DOUBLE_EN
                    state_next = WAIT2;
`else
                    state_next = IDLE;
                    set_single = 1'b1;
`endif
                end else if (tmr_done) begin
                    state_next = LONG_HELD;
                    set_long   = 1'b1;
                end
            end
`ifdef BUTTON_GESTURE_DOUBLE_EN
            WAIT2: begin
                tmr_en    = 1'b1;
                tmr_limit = DBL_LIM_V;
                if (pressed) begin
                    state_next = PRESS2;
                end else if (tmr_done) begin
                    state_next = IDLE;
                    set_single = 1'b1;
                end
            end
            PRESS2: begin
                if (!pressed) begin
                    state_next = IDLE;
                    set_double = 1'b1;
                end
            end
`endif
            LONG_HELD: begin
                if (!pressed) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        tmr_clear = (state_next != state);
    end

    // State, arming and registered outputs; arming waits for a sampled release
    // so a button held through reset cannot start a gesture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            evt_single <= 1'b0;
            evt_long   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            armed      <= armed | ~pressed;
            evt_single <= set_single;
            evt_long   <= set_long;
            busy       <= (state_next != IDLE);
        end
    end

`ifdef BUTTON_GESTURE_DOUBLE_EN
    // Double-press pulse register, present only when double detection is built.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_double <= 1'b0;
        end else begin
            evt_double <= set_double;
        end
    end
`else
    assign evt_double = 1'b0;
`endif

endmodule
